mips_trace_buffer: RTL and testbench
====================================

// Module: mips_trace_buffer
// PURPOSE
//  Downstream consumer of the single-cycle core's registered mips_PC/mips_result pair.
//  Captures one (PC, result, seq) record per retired instruction into a FIFO.
//  A slower debug/UART/host side drains the FIFO over a valid/ready handshake.
//  Repeated PC values are de-duplicated (reset hold, self-loop), so only PC changes are logged.
// PARAMETERS
//  DATA_W   32  width of mips_PC and mips_result
//  DEPTH    16  FIFO entries; must be a power of two
//  ADDR_W    4  log2(DEPTH)
//  SEQ_W    16  width of the sequence tag and the overflow counter
// PORTS
//  in_clock      in   1         clock, rising edge
//  reset         in   1         asynchronous, active-low
//  clear         in   1         sync flush: empty FIFO, zero seq/overflow, re-arm
//  trace_en      in   1         capture enable
//  mips_PC       in   DATA_W    PC from core (registered in core)
//  mips_result   in   DATA_W    ALU result from core (registered in core)
//  out_valid     out  1         head record present
//  out_ready     in   1         consumer accepts head record
//  out_pc        out  DATA_W    head record PC
//  out_result    out  DATA_W    head record result
//  out_seq       out  SEQ_W     head record sequence tag
//  level         out  ADDR_W+1  entries held, 0..DEPTH
//  full          out  1         level==DEPTH
//  overflow_cnt  out  SEQ_W     records dropped because FIFO full; saturates at all-ones
// BEHAVIOUR
//  Reset (reset=0, async): FIFO empty; level=0, full=0, out_valid=0, out_pc/out_result/out_seq=0,
//   overflow_cnt=0, seq counter=0, last_pc=0, FSM=IDLE. Reset mid-traffic discards all contents.
//  Capture FSM (state updates on rising in_clock):
//   IDLE : no capture; trace_en=1 -> FIRST.
//   FIRST: sample captured unconditionally; last_pc<=mips_PC; -> RUN (IDLE if trace_en=0).
//   RUN  : capture iff mips_PC!=last_pc; last_pc<=mips_PC on capture; trace_en=0 -> IDLE.
//  Capture event: record {mips_PC, mips_result, seq}; seq increments (mod 2^SEQ_W) on every
//   capture event, accepted or dropped, so the consumer detects gaps by seq discontinuity.
//  Push: capture event and (not full, or pop in same cycle). Full+capture without pop -> drop,
//   overflow_cnt+1 (saturating); record not stored.
//  Pop: out_valid && out_ready at rising edge; head advances.
//  Simultaneous push+pop: both take effect; level unchanged (also when full or level==1).
//  Pop when empty: ignored. out_ready is irrelevant while out_valid=0.
//  Output is first-word-fall-through: record pushed at edge N is on out_* with out_valid=1
//   right after edge N when FIFO was empty (latency 1 clock from sampled input).
//  out_pc/out_result/out_seq hold stable while out_valid=1 and out_ready=0.
//  Pointers are ADDR_W bits and wrap modulo DEPTH; full/empty come from level, not pointers.
//  clear=1: highest priority over push/pop; next state identical to reset except async timing.
//  trace_en drop mid-stream: stored records remain and drain normally.
// STRUCTURE
//  Package mips_trace_pkg: DATA_W/SEQ_W defaults, record struct/width constant
//   (REC_W = 2*DATA_W+SEQ_W), FSM state encodings IDLE/FIRST/RUN.
//  Sub-module trace_fifo: REC_W x DEPTH storage, rd/wr pointers, level, FWFT head.
//  Top level holds the capture FSM, last_pc, seq counter, overflow counter.
// TESTING
//  1 trace_en=1, PC 0,4,8,C, results 1..4, out_ready=1 -> records seq 0..3, PCs 0,4,8,C in order.
//  2 PC held at 0x10 for 5 cycles, then 0x14 -> exactly two records (0x10, 0x14), seq 0,1.
//  3 out_ready=0, 20 distinct PCs, DEPTH=16 -> full=1, level=16, overflow_cnt=4;
//    drained seq values 0..15.
//  4 full, then push+pop same cycle -> level stays 16, overflow_cnt unchanged, new record at tail.
//  5 reset=0 asserted mid-drain with level=7 -> immediately out_valid=0, level=0, overflow_cnt=0;
//    after release, the first capture gets seq=0.
//  6 clear=1 with capture and pop in same cycle -> level=0, seq=0, next capture taken as FIRST.

Source files
------------

// File: rtl/mips_trace_buffer_pkg.sv
// Shared definitions for the MIPS retirement trace buffer.
//   DATA_W_DEF / SEQ_W_DEF : default PC/result and sequence-tag widths
//   REC_W                  : width of one stored record {pc, result, seq}
//   trace_rec_t            : record layout at the default widths
//   cap_state_e            : capture FSM states
package mips_trace_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int SEQ_W_DEF  = 16;
    localparam int REC_W      = 2 * DATA_W_DEF + SEQ_W_DEF;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] result;
        logic [SEQ_W_DEF-1:0]  seq;
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2
    } cap_state_e;

endpackage

// File: rtl/mips_trace_buffer_fifo.sv
// First-word-fall-through record FIFO for the trace buffer.
//   in_clock / reset : clock, async active-low reset
//   clear            : synchronous flush, wins over push and pop
//   i_wr / i_data    : capture request and record to store
//   i_ready          : consumer accepts head record
//   o_valid / o_data : head record (zero while empty)
//   o_level / o_full : occupancy 0..DEPTH, level==DEPTH
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int WIDTH  = REC_W,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              in_clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              i_wr,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [WIDTH-1:0]  o_data,
    output logic [ADDR_W:0]   o_level,
    output logic              o_full
);

    localparam logic [ADDR_W:0] LVL_FULL = DEPTH[ADDR_W:0];

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;

    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_level == '0);
    assign o_full  = (r_level == LVL_FULL);
    assign o_valid = !w_empty;
    assign o_level = r_level;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_pop   = i_ready && !w_empty;
    assign w_push  = i_wr && (!o_full || w_pop);
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge in_clock) begin
        if (w_push && !clear)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge in_clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/mips_trace_buffer.sv
// Retirement trace buffer: logs one {PC, result, seq} record each time the
// core's registered PC changes, and lets a slow consumer drain them.
//   in_clock / reset        : clock, async active-low reset
//   clear                   : sync flush of FIFO, seq, overflow count and FSM
//   trace_en                : capture enable
//   mips_PC / mips_result   : registered outputs of the core
//   out_valid / out_ready   : FWFT head handshake
//   out_pc/out_result/out_seq : head record
//   level / full            : FIFO occupancy
//   overflow_cnt            : records dropped on full (saturating)
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SEQ_W  = 16
) (
    input  logic              in_clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              trace_en,
    input  logic [DATA_W-1:0] mips_PC,
    input  logic [DATA_W-1:0] mips_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_result,
    output logic [SEQ_W-1:0]  out_seq,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic [SEQ_W-1:0]  overflow_cnt
);

    localparam int W_REC = 2 * DATA_W + SEQ_W;

    cap_state_e        r_state;
    logic [DATA_W-1:0] r_last_pc;
    logic [SEQ_W-1:0]  r_seq;
    logic [SEQ_W-1:0]  r_ovf;

    logic              w_capture;
    logic              w_pop;
    logic              w_drop;
    logic [W_REC-1:0]  w_head;

    // FIRST logs unconditionally so a fresh trace always has an anchor record;
    // RUN only logs PC changes (reset hold / self-loop collapse to one entry).
    assign w_capture = (r_state == ST_FIRST) ||
                       ((r_state == ST_RUN) && (mips_PC != r_last_pc));
    assign w_pop     = out_valid && out_ready;
    assign w_drop    = w_capture && full && !w_pop;

    trace_fifo #(
        .WIDTH  (W_REC),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .in_clock (in_clock),
        .reset    (reset),
        .clear    (clear),
        .i_wr     (w_capture),
        .i_data   ({mips_PC, mips_result, r_seq}),
        .i_ready  (out_ready),
        .o_valid  (out_valid),
        .o_data   (w_head),
        .o_level  (level),
        .o_full   (full)
    );

    assign {out_pc, out_result, out_seq} = w_head;
    assign overflow_cnt = r_ovf;

    always_ff @(posedge in_clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_last_pc <= '0;
            r_seq     <= '0;
            r_ovf     <= '0;
        end else if (clear) begin
            r_state   <= ST_IDLE;
            r_last_pc <= '0;
            r_seq     <= '0;
            r_ovf     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (trace_en) r_state <= ST_FIRST;
                end
                ST_FIRST: begin
                    r_last_pc <= mips_PC;
                    r_state   <= trace_en ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (w_capture) r_last_pc <= mips_PC;
                    if (!trace_en) r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            // seq advances on dropped captures too, so gaps are visible downstream.
            if (w_capture)                r_seq <= r_seq + 1'b1;
            if (w_drop && (r_ovf != '1))  r_ovf <= r_ovf + 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_trace_buffer.sv
module tb_mips_trace_buffer;
    import mips_trace_pkg::*;

    localparam int DW = 32;
    localparam int SW = 16;
    localparam int DP = 16;
    localparam int AW = 4;

    logic          in_clock = 1'b0;
    logic          reset;
    logic          clear;
    logic          trace_en;
    logic [DW-1:0] mips_PC;
    logic [DW-1:0] mips_result;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pc;
    logic [DW-1:0] out_result;
    logic [SW-1:0] out_seq;
    logic [AW:0]   level;
    logic          full;
    logic [SW-1:0] overflow_cnt;

    trace_rec_t exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    mips_trace_buffer #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .SEQ_W(SW)) dut (
        .in_clock     (in_clock),
        .reset        (reset),
        .clear        (clear),
        .trace_en     (trace_en),
        .mips_PC      (mips_PC),
        .mips_result  (mips_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_result   (out_result),
        .out_seq      (out_seq),
        .level        (level),
        .full         (full),
        .overflow_cnt (overflow_cnt)
    );

    always #5 in_clock = ~in_clock;

    function automatic trace_rec_t mk(input logic [DW-1:0] pc, input logic [DW-1:0] res,
                                      input logic [SW-1:0] seq);
        trace_rec_t r;
        r.pc = pc; r.result = res; r.seq = seq;
        return r;
    endfunction

    // One clock: at the falling edge, any handshake that will complete on the
    // next rising edge is checked against the scoreboard head.
    task automatic tick();
        trace_rec_t r;
        @(negedge in_clock);
        if (reset && !clear && out_valid && out_ready) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_record got pc=%h res=%h seq=%0d, expected none",
                         out_pc, out_result, out_seq);
            end else begin
                r = exp_q.pop_front();
                if (out_pc !== r.pc || out_result !== r.result || out_seq !== r.seq)
                    $display("FAIL scoreboard got pc=%h res=%h seq=%0d, expected pc=%h res=%h seq=%0d",
                             out_pc, out_result, out_seq, r.pc, r.result, r.seq);
                else
                    n_pass++;
            end
        end
        @(posedge in_clock);
        #1;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) tick();
        tick();
        n_total++;
        if (exp_q.size() != 0 || level !== '0)
            $display("FAIL %s_drain got pending=%0d level=%0d, expected pending=0 level=0",
                     name, exp_q.size(), level);
        else
            n_pass++;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0; trace_en = 1'b0; out_ready = 1'b0;
        mips_PC = 32'h1234; mips_result = 32'h5678;
        repeat (2) @(posedge in_clock);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || level !== '0 || full !== 1'b0 || overflow_cnt !== '0 ||
            out_pc !== '0 || out_result !== '0 || out_seq !== '0)
            $display("FAIL reset_state got v=%b lvl=%0d full=%b ovf=%0d pc=%h res=%h seq=%0d, expected all zero",
                     out_valid, level, full, overflow_cnt, out_pc, out_result, out_seq);
        else
            n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] pcs [4];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'hC;
        out_ready = 1'b1; trace_en = 1'b1; mips_PC = 32'h0; mips_result = 32'd1;
        tick();
        for (int i = 0; i < 4; i++) begin
            mips_PC = pcs[i]; mips_result = DW'(i + 1);
            exp_q.push_back(mk(pcs[i], DW'(i + 1), SW'(i)));
            tick();
            if (i == 1) begin
                n_total++;
                if (level !== 5'd1)
                    $display("FAIL basic_level_pushpop got %0d, expected 1", level);
                else
                    n_pass++;
            end
        end
        trace_en = 1'b0;
        tick();
        drain("basic");
    endtask

    task automatic test_dedup();
        do_clear();
        out_ready = 1'b1; trace_en = 1'b1; mips_PC = 32'h10; mips_result = 32'hAA;
        tick();
        exp_q.push_back(mk(32'h10, 32'hAA, 16'd0));
        repeat (5) tick();
        mips_PC = 32'h14; mips_result = 32'hBB;
        exp_q.push_back(mk(32'h14, 32'hBB, 16'd1));
        repeat (2) tick();
        trace_en = 1'b0;
        tick();
        drain("dedup");
    endtask

    task automatic test_overflow();
        do_clear();
        out_ready = 1'b0; trace_en = 1'b1; mips_PC = 32'h100; mips_result = 32'h0;
        tick();
        for (int i = 0; i < 20; i++) begin
            mips_PC = 32'h100 + DW'(4 * i); mips_result = 32'h1000 + DW'(i);
            if (i < 16) exp_q.push_back(mk(mips_PC, mips_result, SW'(i)));
            tick();
        end
        trace_en = 1'b0;
        tick();
        n_total++;
        if (full !== 1'b1 || level !== 5'd16 || overflow_cnt !== 16'd4)
            $display("FAIL overflow_state got full=%b lvl=%0d ovf=%0d, expected full=1 lvl=16 ovf=4",
                     full, level, overflow_cnt);
        else
            n_pass++;
        n_total++;
        if (out_valid !== 1'b1 || out_seq !== 16'd0 || out_pc !== 32'h100)
            $display("FAIL overflow_head got v=%b pc=%h seq=%0d, expected v=1 pc=100 seq=0",
                     out_valid, out_pc, out_seq);
        else
            n_pass++;
    endtask

    task automatic test_full_push_pop();
        trace_en = 1'b1;
        tick();
        mips_PC = 32'h900; mips_result = 32'h99; out_ready = 1'b1;
        exp_q.push_back(mk(32'h900, 32'h99, 16'd20));
        tick();
        trace_en = 1'b0; out_ready = 1'b0;
        tick();
        n_total++;
        if (full !== 1'b1 || level !== 5'd16 || overflow_cnt !== 16'd4)
            $display("FAIL full_pushpop got full=%b lvl=%0d ovf=%0d, expected full=1 lvl=16 ovf=4",
                     full, level, overflow_cnt);
        else
            n_pass++;
        drain("full_pushpop");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; trace_en = 1'b1; mips_PC = 32'h200;
        tick();
        for (int i = 0; i < 10; i++) begin
            mips_PC = 32'h200 + DW'(4 * i); mips_result = 32'h2000 + DW'(i);
            exp_q.push_back(mk(mips_PC, mips_result, SW'(21 + i)));
            tick();
        end
        trace_en = 1'b0;
        tick();
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        n_total++;
        if (level !== 5'd7 || overflow_cnt !== 16'd4)
            $display("FAIL resetmid_pre got lvl=%0d ovf=%0d, expected lvl=7 ovf=4", level, overflow_cnt);
        else
            n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || level !== '0 || full !== 1'b0 || overflow_cnt !== '0)
            $display("FAIL resetmid_async got v=%b lvl=%0d full=%b ovf=%0d, expected 0 0 0 0",
                     out_valid, level, full, overflow_cnt);
        else
            n_pass++;
        exp_q.delete();
        #2 reset = 1'b1;
        trace_en = 1'b1; mips_PC = 32'h300; mips_result = 32'h33; out_ready = 1'b1;
        tick();
        exp_q.push_back(mk(32'h300, 32'h33, 16'd0));
        tick();
        trace_en = 1'b0;
        tick();
        drain("resetmid");
    endtask

    task automatic test_clear();
        out_ready = 1'b0; trace_en = 1'b1; mips_PC = 32'h400; mips_result = 32'h44;
        tick();
        tick();
        mips_PC = 32'h404; mips_result = 32'h45;
        tick();
        n_total++;
        if (level !== 5'd2 || out_seq !== 16'd1)
            $display("FAIL clear_pre got lvl=%0d seq=%0d, expected lvl=2 seq=1", level, out_seq);
        else
            n_pass++;
        clear = 1'b1; out_ready = 1'b1; mips_PC = 32'h408; mips_result = 32'h46;
        tick();
        clear = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        n_total++;
        if (level !== '0 || out_valid !== 1'b0 || overflow_cnt !== '0)
            $display("FAIL clear_flush got lvl=%0d v=%b ovf=%0d, expected 0 0 0",
                     level, out_valid, overflow_cnt);
        else
            n_pass++;
        tick();
        n_total++;
        if (level !== '0)
            $display("FAIL clear_idle got lvl=%0d, expected 0", level);
        else
            n_pass++;
        tick();
        n_total++;
        if (level !== 5'd1 || out_seq !== 16'd0 || out_pc !== 32'h408 || out_result !== 32'h46)
            $display("FAIL clear_first got lvl=%0d pc=%h res=%h seq=%0d, expected lvl=1 pc=408 res=46 seq=0",
                     level, out_pc, out_result, out_seq);
        else
            n_pass++;
        exp_q.push_back(mk(32'h408, 32'h46, 16'd0));
        trace_en = 1'b0;
        drain("clear");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dedup();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
